// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment vectors are {g,f,e,d,c,b,a}, active low.
package seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;

  localparam int          NDIG      = 8;
  localparam seg_t        SEG_BLANK = 7'h7F;
  localparam logic [7:0]  AN_OFF    = 8'hFF;

  // Bit i set when digits 7..i are all zero; digit 0 is never blanked.
  function automatic logic [NDIG-1:0] lz_mask(input logic [4*NDIG-1:0] word);
    logic [NDIG-1:0] mask;
    logic            seen_nonzero;
    mask         = '0;
    seen_nonzero = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (word[4*i +: 4] != 4'h0) seen_nonzero = 1'b1;
      mask[i] = ~seen_nonzero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_decode_hex7seg.sv
// Combinational hex-digit to seven-segment glyph decode.
// Output is active low, bit order {g,f,e,d,c,b,a}; A-F render as A b C d E F.
module hex7seg
  import seg_pkg::*;
(
  input  digit_t digit,
  output seg_t   seg
);

  // NOTE: a full case with a default assignment first keeps this purely
  // combinational; a missing branch would otherwise infer a latch.
  always_comb begin
    seg = SEG_BLANK;
    unique case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_decode.sv
// Time-multiplexed 8-digit seven-segment driver with registered pin outputs.
// Optional leading-zero blanking is enabled by defining SEG_LZ_BLANK_EN.
module seg_scan_decode
  import seg_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  input  logic        en,
  output logic [7:0]  an,
  output logic [6:0]  h,
  output logic [2:0]  idx
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DIV_W-1:0] prescaler;
  logic             tick;
  logic [31:0]      shadow;
  digit_t           nibble;
  seg_t             glyph;
  logic [7:0]       an_next;
  logic             blank_sel;

  assign tick = (prescaler == DIV_W'(DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would make the result depend on order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      idx       <= 3'd0;
    end else if (tick) begin
      prescaler <= '0;
      idx       <= idx + 3'd1;
    end else begin
      prescaler <= prescaler + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow <= 32'h0;
    else if (load) shadow <= data;
  end

  assign nibble  = shadow[4*idx +: 4];
  assign an_next = ~(8'b1 << idx);

  hex7seg u_hex7seg (
    .digit (nibble),
    .seg   (glyph)
  );

`ifdef SEG_LZ_BLANK_EN
  logic [NDIG-1:0] blank_mask;
  assign blank_mask = lz_mask(shadow);
  assign blank_sel  = blank_mask[idx];
`else
  assign blank_sel  = 1'b0;
`endif

  // Pins come straight from flops so a decode glitch never reaches the anodes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an <= AN_OFF;
      h  <= SEG_BLANK;
    end else if (en) begin
      an <= an_next;
      h  <= blank_sel ? SEG_BLANK : glyph;
    end else begin
      an <= AN_OFF;
      h  <= SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_seg_scan_decode.sv
// Directed self-checking bench for seg_scan_decode with DIV = 4.
// Honours SEG_LZ_BLANK_EN when it is defined for the build.
module tb_seg_scan_decode;

  localparam int DIV = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        load = 1'b0;
  logic [31:0] data = 32'h0;
  logic        en   = 1'b0;
  logic [7:0]  an;
  logic [6:0]  h;
  logic [2:0]  idx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg_scan_decode #(.DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (data),
    .en   (en),
    .an   (an),
    .h    (h),
    .idx  (idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] d);
    case (d)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic ref_blank(input logic [31:0] w, input int i);
`ifdef SEG_LZ_BLANK_EN
    return (i != 0) && ((w >> (4 * i)) == 32'h0);
`else
    return 1'b0;
`endif
  endfunction

  // Slot visible on the pins after edge n (outputs lag idx by one cycle).
  function automatic int slot(input int n);
    return ((n - 1) / DIV) % 8;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic load_word(input logic [31:0] w);
    data = w;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic scan_check(input string tag, input logic [31:0] w, input int ncyc);
    int         s;
    logic [7:0] e_an;
    logic [6:0] e_h;
    repeat (ncyc) begin
      step();
      s    = slot(cyc);
      e_an = ~(8'b1 << s);
      e_h  = ref_blank(w, s) ? 7'h7F : ref_glyph(4'((w >> (4 * s)) & 32'hF));
      check($sformatf("%s_an_c%0d", tag, cyc), 32'(an), 32'(e_an));
      check($sformatf("%s_h_c%0d", tag, cyc), 32'(h), 32'(e_h));
      check($sformatf("%s_idx_c%0d", tag, cyc), 32'(idx), 32'((cyc / DIV) % 8));
    end
  endtask

  initial begin
    logic [7:0] e_an;

    #12;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_h", 32'(h), 32'h7F);
    check("rst_idx", 32'(idx), 32'h0);

    // Scan order, wrap back to digit 0, one glyph per digit value.
    do_reset();
    en = 1'b1;
    load_word(32'h76543210);
    scan_check("scan", 32'h76543210, 32);

    do_reset();
    load_word(32'hFEDCBA98);
    scan_check("glyph", 32'hFEDCBA98, 32);

    // Enable gating: pins blank, scan keeps counting.
    en = 1'b0;
    repeat (10) begin
      step();
      check($sformatf("en0_an_c%0d", cyc), 32'(an), 32'hFF);
      check($sformatf("en0_h_c%0d", cyc), 32'(h), 32'h7F);
      check($sformatf("en0_idx_c%0d", cyc), 32'(idx), 32'((cyc / DIV) % 8));
    end
    en = 1'b1;
    step();
    e_an = ~(8'b1 << slot(cyc));
    check("en1_an", 32'(an), 32'(e_an));
    check("en1_h", 32'(h), 32'(ref_glyph(4'((32'hFEDCBA98 >> (4 * slot(cyc))) & 32'hF))));

    // Load coinciding with the tick edge.
    while (cyc % DIV != DIV - 1) step();
    load_word(32'h11111111);
    check("col_idx_tick", 32'(idx), 32'((cyc / DIV) % 8));
    step();
    e_an = ~(8'b1 << ((cyc / DIV) % 8));
    check("col_an", 32'(an), 32'(e_an));
    check("col_h", 32'(h), 32'h79);
    repeat (6) begin
      step();
      check($sformatf("col_h_c%0d", cyc), 32'(h), 32'h79);
    end

    // Asynchronous reset mid-scan, then restart from digit 0.
    step();
    #2 rst = 1'b1;
    #1;
    check("arst_an", 32'(an), 32'hFF);
    check("arst_h", 32'(h), 32'h7F);
    check("arst_idx", 32'(idx), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    repeat (2 * DIV) begin
      step();
      check($sformatf("rel_idx_c%0d", cyc), 32'(idx), 32'((cyc / DIV) % 8));
    end

    // Leading zeros (blanked only when SEG_LZ_BLANK_EN is defined).
    load_word(32'h00000A05);
    scan_check("lz_a05", 32'h00000A05, 32);
    load_word(32'h00000000);
    scan_check("lz_zero", 32'h00000000, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
